cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 124 ++++++++++++
 tb/tb_cpu_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// cpu_sequencer: FETCH/EXEC1/EXEC2 phase sequencer with single-step PAUSE and STP HALT.
// Define SEQ_PERF_CNT_EN to build the cycle/instruction performance counters.
module cpu_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RUN,
  input  logic [3:0]  IR,
  input  logic        EXTRA,
  input  logic        MEM_READY,
  input  logic        STEP_MODE,
  input  logic        STEP,
  output logic        FETCH,
  output logic        EXEC1,
  output logic        EXEC2,
  output logic        IR_LOAD,
  output logic        HALTED,
  output logic [2:0]  STATE,
  output logic [15:0] CYCLE_CNT,
  output logic [15:0] INSTR_CNT
);

  localparam logic [3:0] OP_STP = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_PAUSE = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;
  state_t retire_tgt;
  logic   step_q;
  logic   step_rise;

  assign step_rise  = STEP & ~step_q;
  assign retire_tgt = STEP_MODE ? S_PAUSE : S_FETCH;

  // The STEP edge register tracks every cycle so a level held across PAUSE entry is not an edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      step_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= STEP;
    end
  end

  always_comb begin
    state_nxt = state;
    FETCH     = 1'b0;
    EXEC1     = 1'b0;
    EXEC2     = 1'b0;
    IR_LOAD   = 1'b0;
    HALTED    = 1'b0;
    case (state)
      S_IDLE: begin
        if (RUN) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        FETCH = 1'b1;
        if (MEM_READY) begin
          IR_LOAD   = 1'b1;
          state_nxt = S_EXEC1;
        end
      end
      S_EXEC1: begin
        EXEC1 = 1'b1;
        if (IR == OP_STP)  state_nxt = S_HALT;
        else if (EXTRA)    state_nxt = S_EXEC2;
        else               state_nxt = retire_tgt;
      end
      S_EXEC2: begin
        EXEC2 = 1'b1;
        if (MEM_READY) state_nxt = retire_tgt;
      end
      S_PAUSE: begin
        if (step_rise || !STEP_MODE) state_nxt = S_FETCH;
      end
      S_HALT: begin
        HALTED = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign STATE = state;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt;
  logic [15:0] instr_cnt;
  logic        active;
  logic        retire;

  assign active = (state == S_FETCH) || (state == S_EXEC1) ||
                  (state == S_EXEC2) || (state == S_PAUSE);
  // An instruction retires when EXEC1 leaves anywhere but EXEC2, or EXEC2 completes.
  assign retire = ((state == S_EXEC1) && (state_nxt != S_EXEC2)) ||
                  ((state == S_EXEC2) && MEM_READY);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycle_cnt <= 16'd0;
      instr_cnt <= 16'd0;
    end else begin
      if (active && (cycle_cnt != 16'hFFFF)) cycle_cnt <= cycle_cnt + 16'd1;
      if (retire && (instr_cnt != 16'hFFFF)) instr_cnt <= instr_cnt + 16'd1;
    end
  end

  assign CYCLE_CNT = cycle_cnt;
  assign INSTR_CNT = instr_cnt;
`else
  assign CYCLE_CNT = 16'd0;
  assign INSTR_CNT = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// tb_cpu_sequencer: vector table, directed corner sequences and random stimulus vs a reference model.
module tb_cpu_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, RUN, EXTRA, MEM_READY, STEP_MODE, STEP;
  logic [3:0]  IR;
  logic        FETCH, EXEC1, EXEC2, IR_LOAD, HALTED;
  logic [2:0]  STATE;
  logic [15:0] CYCLE_CNT, INSTR_CNT;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 CLK = ~CLK;

  cpu_sequencer dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .IR(IR), .EXTRA(EXTRA),
    .MEM_READY(MEM_READY), .STEP_MODE(STEP_MODE), .STEP(STEP),
    .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .IR_LOAD(IR_LOAD),
    .HALTED(HALTED), .STATE(STATE), .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT)
  );

  // Reference model: debug state code, previous STEP level, counters.
  int m_state, m_cyc, m_ins;
  bit m_step_prev;
  bit m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] dut_vec();
    return {STATE, FETCH, EXEC1, EXEC2, IR_LOAD, HALTED, CYCLE_CNT, INSTR_CNT};
  endfunction

  function automatic logic [39:0] model_vec(input bit mr);
    logic [15:0] c, n;
    c = PERF ? 16'(m_cyc) : 16'd0;
    n = PERF ? 16'(m_ins) : 16'd0;
    return {3'(m_state), m_state == 1, m_state == 2, m_state == 3,
            (m_state == 1) && mr, m_state == 5, c, n};
  endfunction

  task automatic model_step(input bit rst, input bit run, input logic [3:0] ir,
                            input bit extra, input bit mr, input bit sm, input bit st);
    int nxt;
    bit ret;
    if (rst) begin
      m_state = 0; m_step_prev = 0; m_cyc = 0; m_ins = 0; m_valid = 1;
      return;
    end
    nxt = m_state;
    ret = 0;
    case (m_state)
      0: if (run) nxt = 1;
      1: if (mr) nxt = 2;
      2: begin
        ret = 1;
        if (ir == 4'b0111) nxt = 5;
        else if (extra) begin nxt = 3; ret = 0; end
        else nxt = sm ? 4 : 1;
      end
      3: if (mr) begin ret = 1; nxt = sm ? 4 : 1; end
      4: if ((st && !m_step_prev) || !sm) nxt = 1;
      default: ;
    endcase
    if (m_state >= 1 && m_state <= 4 && m_cyc < 65535) m_cyc++;
    if (ret && m_ins < 65535) m_ins++;
    m_step_prev = st;
    m_state = nxt;
  endtask

  // Called at a negedge: drive, compare against model, advance one clock.
  task automatic tick(input bit rst, input bit run, input logic [3:0] ir,
                      input bit extra, input bit mr, input bit sm, input bit st);
    RESET = rst; RUN = run; IR = ir; EXTRA = extra;
    MEM_READY = mr; STEP_MODE = sm; STEP = st;
    #1;
    if (m_valid) check("model", {24'd0, dut_vec()}, {24'd0, model_vec(mr)});
    @(posedge CLK);
    model_step(rst, run, ir, extra, mr, sm, st);
    @(negedge CLK);
  endtask

  typedef struct {
    bit          rst, run;
    logic [3:0]  ir;
    bit          extra, mr;
    logic [2:0]  state;
    bit          irl;
    logic [15:0] cyc, ins;
  } row_t;

  row_t rows[20];

  function automatic row_t mk(input bit rst, input bit run, input logic [3:0] ir, input bit extra,
                              input bit mr, input logic [2:0] state, input bit irl,
                              input logic [15:0] cyc, input logic [15:0] ins);
    row_t r;
    r.rst = rst; r.run = run; r.ir = ir; r.extra = extra; r.mr = mr;
    r.state = state; r.irl = irl; r.cyc = cyc; r.ins = ins;
    return r;
  endfunction

  initial begin
    RESET = 1; RUN = 0; IR = 4'd0; EXTRA = 0; MEM_READY = 0; STEP_MODE = 0; STEP = 0;

    // JMP stream, reset mid-instruction, LDA with wait states, reset in FETCH.
    rows[0]  = mk(0, 1, 4'b0100, 0, 1, 3'd0, 0, 0, 0);
    rows[1]  = mk(0, 0, 4'b0100, 0, 1, 3'd1, 1, 0, 0);
    rows[2]  = mk(0, 0, 4'b0100, 0, 1, 3'd2, 0, 1, 0);
    rows[3]  = mk(0, 0, 4'b0100, 0, 1, 3'd1, 1, 2, 1);
    rows[4]  = mk(0, 0, 4'b0100, 0, 1, 3'd2, 0, 3, 1);
    rows[5]  = mk(0, 0, 4'b0100, 0, 1, 3'd1, 1, 4, 2);
    rows[6]  = mk(0, 0, 4'b0100, 0, 1, 3'd2, 0, 5, 2);
    rows[7]  = mk(0, 0, 4'b0100, 0, 1, 3'd1, 1, 6, 3);
    rows[8]  = mk(1, 0, 4'b0100, 0, 1, 3'd2, 0, 7, 3);
    rows[9]  = mk(0, 0, 4'b0100, 0, 1, 3'd0, 0, 0, 0);
    rows[10] = mk(0, 1, 4'b0000, 1, 0, 3'd0, 0, 0, 0);
    rows[11] = mk(0, 0, 4'b0000, 1, 0, 3'd1, 0, 0, 0);
    rows[12] = mk(0, 0, 4'b0000, 1, 0, 3'd1, 0, 1, 0);
    rows[13] = mk(0, 0, 4'b0000, 1, 1, 3'd1, 1, 2, 0);
    rows[14] = mk(0, 0, 4'b0000, 1, 0, 3'd2, 0, 3, 0);
    rows[15] = mk(0, 0, 4'b0000, 1, 0, 3'd3, 0, 4, 0);
    rows[16] = mk(0, 0, 4'b0000, 1, 1, 3'd3, 0, 5, 0);
    rows[17] = mk(0, 0, 4'b0000, 1, 0, 3'd1, 0, 6, 1);
    rows[18] = mk(1, 0, 4'b0000, 1, 0, 3'd1, 0, 7, 1);
    rows[19] = mk(0, 0, 4'b0000, 1, 0, 3'd0, 0, 0, 0);

    @(negedge CLK);
    tick(1, 0, 4'd0, 0, 0, 0, 0);
    tick(1, 0, 4'd0, 0, 0, 0, 0);

    foreach (rows[i]) begin
      RESET = rows[i].rst; RUN = rows[i].run; IR = rows[i].ir; EXTRA = rows[i].extra;
      MEM_READY = rows[i].mr; STEP_MODE = 0; STEP = 0;
      #1;
      check($sformatf("row%0d", i),
            {24'd0, STATE, IR_LOAD, HALTED, CYCLE_CNT, INSTR_CNT},
            {24'd0, rows[i].state, rows[i].irl, 1'b0,
             PERF ? rows[i].cyc : 16'd0, PERF ? rows[i].ins : 16'd0});
      tick(rows[i].rst, rows[i].run, rows[i].ir, rows[i].extra, rows[i].mr, 1'b0, 1'b0);
    end

    // LDI then STP: HALT is sticky against RUN/STEP/MEM_READY.
    tick(1, 0, 4'd0, 0, 0, 0, 0);
    tick(0, 1, 4'b0001, 0, 1, 0, 0);
    tick(0, 0, 4'b0001, 0, 1, 0, 0);
    tick(0, 0, 4'b0001, 0, 1, 0, 0);
    tick(0, 0, 4'b0111, 0, 1, 0, 0);
    tick(0, 0, 4'b0111, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 4'b0111, 1, i[0], 0, i[0]);
    #1;
    check("halt", {40'd0, STATE, HALTED, CYCLE_CNT, INSTR_CNT},
          {40'd0, 3'd5, 1'b1, PERF ? 16'd4 : 16'd0, PERF ? 16'd2 : 16'd0});

    // Single-step: STEP held high into PAUSE must not advance; each rising edge releases once.
    tick(1, 0, 4'd0, 0, 0, 1, 1);
    tick(0, 1, 4'b0100, 0, 1, 1, 1);
    for (int s = 0; s < 3; s++) begin
      tick(0, 0, 4'b0100, 0, 1, 1, 1);
      tick(0, 0, 4'b0100, 0, 1, 1, 1);
      tick(0, 0, 4'b0100, 0, 1, 1, 1);
      tick(0, 0, 4'b0100, 0, 1, 1, 1);
      #1;
      check("pause_hold", {61'd0, STATE}, {61'd0, 3'd4});
      tick(0, 0, 4'b0100, 0, 1, 1, 0);
      tick(0, 0, 4'b0100, 0, 1, 1, 1);
      #1;
      check("step_edge", {61'd0, STATE}, {61'd0, 3'd1});
    end
    tick(0, 0, 4'b0100, 0, 1, 1, 1);
    tick(0, 0, 4'b0100, 0, 1, 1, 1);
    tick(0, 0, 4'b0100, 0, 1, 0, 1);
    #1;
    check("step_mode_off", {61'd0, STATE}, {61'd0, 3'd1});

    // Reset while in EXEC2.
    tick(1, 0, 4'd0, 0, 0, 0, 0);
    tick(0, 1, 4'd0, 1, 1, 0, 0);
    tick(0, 0, 4'd0, 1, 1, 0, 0);
    tick(0, 0, 4'd0, 1, 0, 0, 0);
    #1;
    check("in_exec2", {61'd0, STATE}, {61'd0, 3'd3});
    tick(1, 1, 4'd0, 1, 1, 1, 1);
    #1;
    check("reset_exec2", {24'd0, dut_vec()}, 64'd0);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] ir_r;
      ir_r = ($urandom_range(0, 15) == 0) ? 4'b0111 : 4'($urandom_range(0, 15));
      if (ir_r == 4'b0111 && $urandom_range(0, 1) == 0) ir_r = 4'b0110;
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, ir_r,
           1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
